// File: rtl/frame_buffer_ctrl_pkg.sv
// frame_buffer_ctrl_pkg
// Shared types and defaults for the dual-bank frame buffer sequencer.
//   fbc_state_e      : sequencer states
//   DEF_*            : default frame size, address width and drain timeout
//   pcnt_width()     : pixel counter width for a given address width
//   PCNT_W           : pixel counter width for the default address width
package frame_buffer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_HOLD    = 3'd2,
        ST_COPY    = 3'd3,
        ST_DRAIN   = 3'd4
    } fbc_state_e;

    localparam int DEF_FRAME_PIXELS = 65536;
    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DRAIN_MAX    = 4;

    // One extra bit so the pixel counter can represent a full frame
    // (FRAME_PIXELS == 2^ADDR_W) and detect overflow pixels.
    function automatic int pcnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

    localparam int PCNT_W = pcnt_width(DEF_ADDR_W);

endpackage

// File: rtl/frame_buffer_ctrl_pix_addr_counter.sv
// pix_addr_counter
// Registered up-counter with clear, load and terminal-count flag.
//   clk, rst  : system clock, synchronous active-high reset
//   clr       : force count to zero (highest priority)
//   load      : load load_val
//   inc       : increment by one
//   cnt_q     : current count
//   tc        : cnt_q equals TERM
module pix_addr_counter #(
    parameter int             W    = 17,
    parameter logic [W-1:0]   TERM = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] cnt_q,
    output logic         tc
);

    logic [W-1:0] cnt_d;

    // Next-count selection: clear, then load, then increment.
    always_comb begin
        if (clr) begin
            cnt_d = W'(0);
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= W'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TERM);

endmodule

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl
// Sequencer for a capture/display dual-bank frame buffer. Camera pixels are
// written into the capture bank; on a display request the whole frame is
// swept out (capture -> display copy), then the read port returns to the
// VGA address. All outputs are registered.
//   clk, rst            : system clock, synchronous active-high reset
//   frame_start         : camera VSYNC pulse
//   pix_valid, pix_data : pixel strobe and RGB565 data
//   copy_req            : display-side request for a bank copy
//   vga_addr            : display read address
//   buf_done            : copy-complete flag from the buffer
//   buf_w_en/addr, buf_d_in : capture-bank write port
//   buf_r_rd, buf_r_addr    : copy-in-progress flag and read address
//   frame_ready, copy_done  : frame held / copy finished pulse
//   ovf_err, drain_err      : sticky error flags
//   drop_cnt                : saturating count of dropped frames
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DRAIN_MAX    = DEF_DRAIN_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [15:0]       pix_data,
    input  logic              copy_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              buf_done,
    output logic [15:0]       buf_d_in,
    output logic [ADDR_W-1:0] buf_w_addr,
    output logic              buf_w_en,
    output logic              buf_r_rd,
    output logic [ADDR_W-1:0] buf_r_addr,
    output logic              frame_ready,
    output logic              copy_done,
    output logic              ovf_err,
    output logic              drain_err,
    output logic [7:0]        drop_cnt
);

    localparam int CNT_W  = pcnt_width(ADDR_W);
    localparam int DCNT_W = $clog2(DRAIN_MAX + 1);

    fbc_state_e        state_q, state_d;
    logic              pend_q, pend_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;

    logic [15:0]       buf_d_in_q, buf_d_in_d;
    logic [ADDR_W-1:0] buf_w_addr_q, buf_w_addr_d;
    logic              buf_w_en_q, buf_w_en_d;
    logic              buf_r_rd_q, buf_r_rd_d;
    logic [ADDR_W-1:0] buf_r_addr_q, buf_r_addr_d;
    logic              frame_ready_q, frame_ready_d;
    logic              copy_done_q, copy_done_d;
    logic              ovf_err_q, ovf_err_d;
    logic              drain_err_q, drain_err_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              drop_evt;
    logic              pcnt_clr, pcnt_inc, pcnt_tc;
    logic [CNT_W-1:0]  pcnt_q;
    logic              scnt_clr, scnt_inc, scnt_tc;
    logic [ADDR_W-1:0] scnt_q;

    // Pixel counter: write address in CAPTURE, terminal at a full frame.
    pix_addr_counter #(
        .W    (CNT_W),
        .TERM (CNT_W'(FRAME_PIXELS))
    ) u_pcnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (pcnt_clr),
        .load     (1'b0),
        .load_val (CNT_W'(0)),
        .inc      (pcnt_inc),
        .cnt_q    (pcnt_q),
        .tc       (pcnt_tc)
    );

    // Sweep counter: held at zero outside COPY so it starts at 0 on entry.
    pix_addr_counter #(
        .W    (ADDR_W),
        .TERM (ADDR_W'(FRAME_PIXELS - 1))
    ) u_scnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (scnt_clr),
        .load     (1'b0),
        .load_val (ADDR_W'(0)),
        .inc      (scnt_inc),
        .cnt_q    (scnt_q),
        .tc       (scnt_tc)
    );

    assign scnt_clr = (state_q != ST_COPY);
    assign scnt_inc = (state_q == ST_COPY);

    // Next-state, error, drop and output-register logic.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        dcnt_d       = dcnt_q;
        buf_d_in_d   = buf_d_in_q;
        buf_w_addr_d = buf_w_addr_q;
        buf_w_en_d   = 1'b0;
        copy_done_d  = 1'b0;
        ovf_err_d    = ovf_err_q;
        drain_err_d  = drain_err_q;
        drop_evt     = 1'b0;
        pcnt_clr     = 1'b0;
        pcnt_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pcnt_clr = 1'b1;
                dcnt_d   = DCNT_W'(0);
                if (copy_req) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (frame_start) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (copy_req) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (pix_valid && (pcnt_q < CNT_W'(FRAME_PIXELS))) begin
                    buf_w_en_d   = 1'b1;
                    buf_w_addr_d = pcnt_q[ADDR_W-1:0];
                    buf_d_in_d   = pix_data;
                    pcnt_inc     = 1'b1;
                end else if (pix_valid) begin
                    ovf_err_d = 1'b1;
                end else begin
                    pcnt_inc = 1'b0;
                end
                // A frame_start coinciding with the last write ends the
                // frame normally; it is not a dropped frame.
                if (frame_start || pcnt_tc) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_HOLD: begin
                pend_d   = 1'b0;
                drop_evt = frame_start;
                if (copy_req || pend_q) begin
                    state_d = ST_COPY;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_COPY: begin
                drop_evt = frame_start;
                if (scnt_tc) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = DCNT_W'(1);
                end else begin
                    state_d = ST_COPY;
                end
            end
            ST_DRAIN: begin
                drop_evt = frame_start;
                // dcnt_q is the 1-based DRAIN cycle number; buf_done is
                // ignored in the first cycle.
                if (buf_done && (dcnt_q >= DCNT_W'(2))) begin
                    state_d     = ST_IDLE;
                    copy_done_d = 1'b1;
                    dcnt_d      = DCNT_W'(0);
                end else if (dcnt_q >= DCNT_W'(DRAIN_MAX)) begin
                    state_d     = ST_IDLE;
                    copy_done_d = 1'b1;
                    drain_err_d = 1'b1;
                    dcnt_d      = DCNT_W'(0);
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                dcnt_d  = DCNT_W'(0);
            end
        endcase

        if (drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        frame_ready_d = (state_d == ST_HOLD) || (state_d == ST_COPY) ||
                        (state_d == ST_DRAIN);
        buf_r_rd_d    = (state_d == ST_COPY) || (state_d == ST_DRAIN);

        // Registered read address tracks the sweep address of the coming
        // cycle in COPY, and the VGA address one cycle late otherwise.
        if (state_d == ST_COPY) begin
            if (state_q == ST_COPY) begin
                buf_r_addr_d = scnt_q + ADDR_W'(1);
            end else begin
                buf_r_addr_d = ADDR_W'(0);
            end
        end else begin
            buf_r_addr_d = vga_addr;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pend_q        <= 1'b0;
            dcnt_q        <= DCNT_W'(0);
            buf_d_in_q    <= 16'h0000;
            buf_w_addr_q  <= ADDR_W'(0);
            buf_w_en_q    <= 1'b0;
            buf_r_rd_q    <= 1'b0;
            buf_r_addr_q  <= ADDR_W'(0);
            frame_ready_q <= 1'b0;
            copy_done_q   <= 1'b0;
            ovf_err_q     <= 1'b0;
            drain_err_q   <= 1'b0;
            drop_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            dcnt_q        <= dcnt_d;
            buf_d_in_q    <= buf_d_in_d;
            buf_w_addr_q  <= buf_w_addr_d;
            buf_w_en_q    <= buf_w_en_d;
            buf_r_rd_q    <= buf_r_rd_d;
            buf_r_addr_q  <= buf_r_addr_d;
            frame_ready_q <= frame_ready_d;
            copy_done_q   <= copy_done_d;
            ovf_err_q     <= ovf_err_d;
            drain_err_q   <= drain_err_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign buf_d_in    = buf_d_in_q;
    assign buf_w_addr  = buf_w_addr_q;
    assign buf_w_en    = buf_w_en_q;
    assign buf_r_rd    = buf_r_rd_q;
    assign buf_r_addr  = buf_r_addr_q;
    assign frame_ready = frame_ready_q;
    assign copy_done   = copy_done_q;
    assign ovf_err     = ovf_err_q;
    assign drain_err   = drain_err_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl
// Directed bench for frame_buffer_ctrl with a 16-pixel frame and 8-bit
// addresses. Inputs change 1ns after a rising edge; outputs are checked at
// the same point, so each check sees the result of the edge just taken.
module tb_frame_buffer_ctrl;

    localparam int FP = 16;
    localparam int AW = 8;
    localparam int DM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          pix_valid;
    logic [15:0]   pix_data;
    logic          copy_req;
    logic [AW-1:0] vga_addr;
    logic          buf_done;
    logic [15:0]   buf_d_in;
    logic [AW-1:0] buf_w_addr;
    logic          buf_w_en;
    logic          buf_r_rd;
    logic [AW-1:0] buf_r_addr;
    logic          frame_ready;
    logic          copy_done;
    logic          ovf_err;
    logic          drain_err;
    logic [7:0]    drop_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    frame_buffer_ctrl #(
        .FRAME_PIXELS (FP),
        .ADDR_W       (AW),
        .DRAIN_MAX    (DM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .copy_req    (copy_req),
        .vga_addr    (vga_addr),
        .buf_done    (buf_done),
        .buf_d_in    (buf_d_in),
        .buf_w_addr  (buf_w_addr),
        .buf_w_en    (buf_w_en),
        .buf_r_rd    (buf_r_rd),
        .buf_r_addr  (buf_r_addr),
        .frame_ready (frame_ready),
        .copy_done   (copy_done),
        .ovf_err     (ovf_err),
        .drain_err   (drain_err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = 16'h0000;
        copy_req = 1'b0; vga_addr = 8'h00; buf_done = 1'b0;
        step();
        step();

        // Reset state.
        chk("rst_w_en", 32'(buf_w_en), 32'd0);
        chk("rst_w_addr", 32'(buf_w_addr), 32'd0);
        chk("rst_d_in", 32'(buf_d_in), 32'd0);
        chk("rst_r_rd", 32'(buf_r_rd), 32'd0);
        chk("rst_r_addr", 32'(buf_r_addr), 32'd0);
        chk("rst_ready", 32'(frame_ready), 32'd0);
        chk("rst_done", 32'(copy_done), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_drain", 32'(drain_err), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // Four pixels: each write appears one cycle after its strobe.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t1_no_write_yet", 32'(buf_w_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(i + 1);
            step();
            chk("t1_w_en", 32'(buf_w_en), 32'd1);
            chk("t1_w_addr", 32'(buf_w_addr), 32'(i));
            chk("t1_d_in", 32'(buf_d_in), 32'(i + 1));
            chk("t1_ready", 32'(frame_ready), 32'd0);
        end
        pix_valid = 1'b0;
        step();
        chk("t1_w_en_off", 32'(buf_w_en), 32'd0);
        chk("t1_ready_off", 32'(frame_ready), 32'd0);

        // Fresh frame with 20 strobes: 16 writes, then overflow and HOLD.
        rst = 1'b1;
        step();
        rst = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'h0100 + 16'(i);
            step();
            if (i < FP) begin
                chk("t2_w_en", 32'(buf_w_en), 32'd1);
                chk("t2_w_addr", 32'(buf_w_addr), 32'(i));
                chk("t2_d_in", 32'(buf_d_in), 32'h100 + 32'(i));
            end else begin
                chk("t2_no_write", 32'(buf_w_en), 32'd0);
            end
            if (i == FP - 1) begin
                chk("t2_ready_before", 32'(frame_ready), 32'd0);
                chk("t2_ovf_before", 32'(ovf_err), 32'd0);
            end else if (i == FP) begin
                chk("t2_ready_set", 32'(frame_ready), 32'd1);
                chk("t2_ovf_set", 32'(ovf_err), 32'd1);
            end
        end
        pix_valid = 1'b0;
        step();
        chk("t2_hold_ready", 32'(frame_ready), 32'd1);
        chk("t2_hold_no_rd", 32'(buf_r_rd), 32'd0);
        chk("t2_hold_ovf", 32'(ovf_err), 32'd1);

        // Copy sweep 0..15, then DRAIN; buf_done from 1st DRAIN cycle is
        // only honoured in the 2nd.
        vga_addr = 8'hA5;
        copy_req = 1'b1;
        step();
        copy_req = 1'b0;
        chk("t3_rd_rise", 32'(buf_r_rd), 32'd1);
        chk("t3_addr0", 32'(buf_r_addr), 32'd0);
        for (int i = 1; i < FP; i++) begin
            step();
            chk("t3_sweep_addr", 32'(buf_r_addr), 32'(i));
            chk("t3_sweep_rd", 32'(buf_r_rd), 32'd1);
            chk("t3_sweep_done", 32'(copy_done), 32'd0);
        end
        step();
        chk("t3_drain1_rd", 32'(buf_r_rd), 32'd1);
        chk("t3_drain1_addr", 32'(buf_r_addr), 32'hA5);
        buf_done = 1'b1;
        step();
        chk("t3_drain2_rd", 32'(buf_r_rd), 32'd1);
        chk("t3_drain2_done", 32'(copy_done), 32'd0);
        vga_addr = 8'h5A;
        step();
        buf_done = 1'b0;
        chk("t3_copy_done", 32'(copy_done), 32'd1);
        chk("t3_rd_fall", 32'(buf_r_rd), 32'd0);
        chk("t3_ready_clr", 32'(frame_ready), 32'd0);
        chk("t3_vga_follow", 32'(buf_r_addr), 32'h5A);
        chk("t3_no_drain_err", 32'(drain_err), 32'd0);
        step();
        chk("t3_done_pulse", 32'(copy_done), 32'd0);

        // copy_req during CAPTURE is held until HOLD is entered.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        copy_req = 1'b1;
        step();
        copy_req = 1'b0;
        pix_valid = 1'b1;
        pix_data  = 16'hBEEF;
        step();
        pix_valid = 1'b0;
        chk("t4_w_en", 32'(buf_w_en), 32'd1);
        chk("t4_w_addr", 32'(buf_w_addr), 32'd0);
        chk("t4_d_in", 32'(buf_d_in), 32'hBEEF);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t4_hold_ready", 32'(frame_ready), 32'd1);
        chk("t4_hold_no_rd", 32'(buf_r_rd), 32'd0);
        step();
        chk("t4_copy_rd", 32'(buf_r_rd), 32'd1);
        chk("t4_copy_addr0", 32'(buf_r_addr), 32'd0);
        chk("t4_no_drop", 32'(drop_cnt), 32'd0);

        // Three frame_starts in COPY (one with an ignored copy_req), then
        // DRAIN timeout with buf_done held low.
        for (int k = 0; k < 3; k++) begin
            frame_start = 1'b1;
            copy_req    = (k == 1);
            step();
            frame_start = 1'b0;
            copy_req    = 1'b0;
            step();
        end
        chk("t5_drop3", 32'(drop_cnt), 32'd3);
        chk("t5_addr6", 32'(buf_r_addr), 32'd6);
        for (int i = 0; i < 9; i++) begin
            step();
        end
        chk("t5_addr15", 32'(buf_r_addr), 32'd15);
        vga_addr = 8'h77;
        step();
        chk("t5_drain_addr", 32'(buf_r_addr), 32'h77);
        for (int i = 0; i < DM - 1; i++) begin
            step();
            chk("t5_drain_rd", 32'(buf_r_rd), 32'd1);
            chk("t5_drain_err_low", 32'(drain_err), 32'd0);
            chk("t5_drain_done_low", 32'(copy_done), 32'd0);
        end
        step();
        chk("t5_drain_err", 32'(drain_err), 32'd1);
        chk("t5_timeout_done", 32'(copy_done), 32'd1);
        chk("t5_timeout_rd", 32'(buf_r_rd), 32'd0);
        chk("t5_timeout_ready", 32'(frame_ready), 32'd0);
        chk("t5_ovf_sticky", 32'(ovf_err), 32'd1);

        // Short empty frame, drop in HOLD, then reset in the 5th COPY cycle.
        frame_start = 1'b1;
        step();
        step();
        frame_start = 1'b0;
        chk("t6_hold_ready", 32'(frame_ready), 32'd1);
        chk("t6_hold_drop", 32'(drop_cnt), 32'd3);
        step();
        chk("t6_no_pending", 32'(buf_r_rd), 32'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t6_drop4", 32'(drop_cnt), 32'd4);
        copy_req = 1'b1;
        step();
        copy_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("t6_copy5_addr", 32'(buf_r_addr), 32'd4);
        chk("t6_copy5_rd", 32'(buf_r_rd), 32'd1);
        rst = 1'b1;
        vga_addr = 8'h3C;
        step();
        rst = 1'b0;
        chk("t6_rst_rd", 32'(buf_r_rd), 32'd0);
        chk("t6_rst_ready", 32'(frame_ready), 32'd0);
        chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
        chk("t6_rst_ovf", 32'(ovf_err), 32'd0);
        chk("t6_rst_drain", 32'(drain_err), 32'd0);
        step();
        chk("t6_vga_follow", 32'(buf_r_addr), 32'h3C);
        chk("t6_idle_rd", 32'(buf_r_rd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Sequencer for the dual-bank frame buffer, which has a capture bank and a display bank. It accepts camera pixel strobes and generates the capture-bank write address and enable. On a display request it runs a full-frame copy sweep from the capture bank into the display bank, and otherwise passes the VGA read address through. It sits between the OV7670 capture front-end and the frame buffer, in the single system clock domain.

## Interface
- FRAME_PIXELS, 65536, pixels per frame (≤ 2^ADDR_W)
- ADDR_W, 16, buffer address width
- DRAIN_MAX, 4, max cycles to wait for buf_done after the sweep ends
- clk  in  1  system clock
- rst  in  1  reset; one clock; synchronous, active-high
- frame_start  in  1  one-cycle pulse at camera VSYNC
- pix_valid  in  1  pixel strobe, at most one per cycle
- pix_data  in  16  RGB565 pixel
- copy_req  in  1  pulse from display side at vblank: request bank copy
- vga_addr  in  ADDR_W  display read address
- buf_done  in  1  copy-complete flag from buffer
- buf_d_in  out  16  write data to capture bank
- buf_w_addr  out  ADDR_W  capture write address
- buf_w_en  out  1  capture write enable
- buf_r_rd  out  1  copy-in-progress flag to buffer
- buf_r_addr  out  ADDR_W  buffer read address
- frame_ready  out  1  complete frame held in capture bank, not yet copied
- copy_done  out  1  one-cycle pulse at end of copy
- ovf_err  out  1  sticky: pixels beyond FRAME_PIXELS dropped
- drain_err  out  1  sticky: buf_done not seen within DRAIN_MAX
- drop_cnt  out  8  frames dropped, saturating at 255

## Operation
- States: IDLE, CAPTURE, HOLD, COPY, DRAIN.
- **IDLE**
  - frame_start → CAPTURE.
  - Pixel counter pcnt (ADDR_W+1 bits) cleared to 0.
- **CAPTURE**
  - Each pix_valid with pcnt < FRAME_PIXELS writes pix_data at address pcnt, then pcnt+1.
  - pix_valid with pcnt == FRAME_PIXELS causes no write and sets ovf_err.
  - The next frame_start, or pcnt reaching FRAME_PIXELS, → HOLD with frame_ready=1.
  - A short frame (frame_start before full) is still held; unwritten addresses keep stale data.
- **HOLD**
  - No writes.
  - copy_req → COPY.
  - Each frame_start in HOLD increments drop_cnt; the held frame is kept.
- **COPY**
  - buf_r_rd=1.
  - Sweep counter scnt runs 0..FRAME_PIXELS-1, one address per cycle; buf_r_addr=scnt.
  - After the last address → DRAIN.
- **DRAIN**
  - buf_r_rd stays 1, buf_r_addr=vga_addr.
  - Exit when buf_done=1 sampled on or after the 2nd DRAIN cycle, or after DRAIN_MAX cycles (sets drain_err).
  - On exit: copy_done pulse, frame_ready=0, → IDLE.
- **Read address mux**
  - buf_r_addr=scnt in COPY, vga_addr in all other states.
- **Simultaneous events and pending requests**
  - copy_req arriving in IDLE or CAPTURE latches a pending flag, consumed on entry to HOLD (HOLD → COPY next cycle).
  - copy_req during COPY or DRAIN is ignored.
  - frame_start during COPY or DRAIN increments drop_cnt; capture does not start.
  - frame_start in the same cycle as the final capture write: the write completes, → HOLD, not counted as a drop.
- **Reset**
  - All outputs 0, state IDLE, counters and sticky flags cleared, pending flag cleared.
  - Reset mid-COPY drops buf_r_rd on the next edge; the display bank contents are undefined.

## Timing
- All outputs are registered.
- Write path latency 1: pix_valid at edge N → buf_w_en, buf_w_addr, buf_d_in valid after edge N+1, held exactly one cycle.
- Copy sweep takes exactly FRAME_PIXELS cycles in COPY, plus 2..DRAIN_MAX cycles in DRAIN.
- buf_r_rd rises on the cycle COPY is entered and falls on the cycle after DRAIN exits.
- Mux switch latency 1: buf_r_addr follows vga_addr one cycle late.
- copy_done and frame_ready=0 take effect in the same cycle.

## Structure
- Package frame_buffer_ctrl_pkg:
  - state enum
  - localparam for the default FRAME_PIXELS and DRAIN_MAX
  - PCNT_W = ADDR_W+1
- Sub-module pix_addr_counter: loadable/clearable counter with terminal-count flag, instantiated twice (pcnt and scnt).

## Test plan
- Reset, then frame_start followed by 4 pix_valid with data 0x0001..0x0004 → writes to addresses 0..3, each one cycle after its strobe; frame_ready stays 0.
- FRAME_PIXELS=16, 20 pix_valid → 16 writes, ovf_err=1, frame_ready=1, state HOLD.
- In HOLD: copy_req → buf_r_rd high for 16 cycles of sweep 0..15 plus DRAIN; buf_done asserted on the 2nd DRAIN cycle → copy_done pulse, buf_r_rd=0 next cycle.
- copy_req during CAPTURE, then frame_start → COPY starts one cycle after HOLD is entered.
- Three frame_start pulses during HOLD/COPY → drop_cnt=3; buf_done held 0 → drain_err=1 after DRAIN_MAX cycles.
- rst asserted in the 5th COPY cycle → next cycle buf_r_rd=0, frame_ready=0, drop_cnt=0, buf_r_addr follows vga_addr.
